// File: rtl/datapath_pkg.sv
// Shared constants, ALU control enum and instruction encoders
// for the single-cycle RV32 datapath.
package datapath_pkg;

   localparam logic [31:0] TEXT_BASE = 32'h0001_0000;
   localparam logic [31:0] DATA_BASE = 32'h1000_0000;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_IMM = 7'b0010011;

   localparam logic [31:0] NOP = {12'd0, 5'd0, 3'b000, 5'd0, OP_IMM};

   typedef enum logic [2:0] {
      ADD,
      SUB,
      AND,
      OR,
      SLT
   } alu_ctrl_e;

   function automatic logic [31:0] enc_r(
      input logic [6:0] f7,
      input logic [4:0] rs2,
      input logic [4:0] rs1,
      input logic [2:0] f3,
      input logic [4:0] rd
   );
      return {f7, rs2, rs1, f3, rd, OP_R};
   endfunction

   function automatic logic [31:0] enc_lw(
      input logic [11:0] imm,
      input logic [4:0]  rs1,
      input logic [4:0]  rd
   );
      return {imm, rs1, 3'b010, rd, OP_LW};
   endfunction

   function automatic logic [31:0] enc_sw(
      input logic [11:0] imm,
      input logic [4:0]  rs2,
      input logic [4:0]  rs1
   );
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
   endfunction

   // hoff is the branch offset already divided by two (imm[12:1])
   function automatic logic [31:0] enc_beq(
      input logic [12:1] hoff,
      input logic [4:0]  rs2,
      input logic [4:0]  rs1
   );
      return {hoff[12], hoff[10:5], rs2, rs1, 3'b000,
              hoff[4:1], hoff[11], OP_BEQ};
   endfunction

endpackage

// File: rtl/datapath_regfile.sv
// 32x32 register file: two async read ports, one sync write port.
// Reset preloads x1=1, x2=2 and x10 with the data-memory base.
module datapath_regfile #(
   parameter logic [31:0] X10_INIT = 32'h1000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  ra1_i,
   input  logic [4:0]  ra2_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i
);

   logic [31:0] regs_q [32];

   // reset preload, otherwise write rd (x0 is never written)
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
         regs_q[1]  <= 32'd1;
         regs_q[2]  <= 32'd2;
         regs_q[10] <= X10_INIT;
      end else if (we_i && (wa_i != 5'd0)) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
   assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/datapath.sv
// Single-cycle RV32 datapath: add/sub/and/or/slt, lw, sw, beq,
// with an internal program ROM and word-addressed data memory.
module datapath #(
   parameter logic [31:0] TEXT_BASE  = datapath_pkg::TEXT_BASE,
   parameter logic [31:0] DATA_BASE  = datapath_pkg::DATA_BASE,
   parameter int          DMEM_WORDS = 64
) (
   input  logic        clock,
   input  logic        clear,
   output logic [31:0] writedata,
   output logic [31:0] dataadr,
   output logic        memwrite
);

   import datapath_pkg::*;

   localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

   logic [31:0] pc_q, pc_d;
   logic [31:0] dmem_q [DMEM_WORDS];
   logic [29:0] ridx, widx;
   logic [31:0] instr;
   logic [6:0]  op, f7;
   logic [2:0]  f3;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm_i, imm_s, imm_b;
   logic [31:0] rd1, rd2, imm, alu_a, alu_b, alu_y;
   logic [31:0] rdata, wb;
   logic        reg_we, mem_we, use_imm, is_beq, mem_to_reg;
   logic        in_range;
   alu_ctrl_e   alu_ctrl;

   assign ridx = 30'((pc_q - TEXT_BASE) >> 2);

   // program ROM, NOP outside the populated words
   always_comb begin
      instr = NOP;
      case (ridx)
         30'd0:  instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
         30'd1:  instr = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3);
         30'd2:  instr = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3);
         30'd3:  instr = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3);
         30'd4:  instr = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3);
         30'd5:  instr = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd3);
         30'd6:  instr = enc_beq(12'hFF4, 5'd0, 5'd10);
         30'd7:  instr = enc_lw(12'd0, 5'd10, 5'd3);
         30'd8:  instr = enc_lw(12'd4, 5'd10, 5'd3);
         30'd9:  instr = enc_sw(12'd8, 5'd3, 5'd10);
         30'd10: instr = enc_beq(12'hFEC, 5'd0, 5'd0);
         default: instr = NOP;
      endcase
   end

   assign op  = instr[6:0];
   assign rd  = instr[11:7];
   assign f3  = instr[14:12];
   assign rs1 = instr[19:15];
   assign rs2 = instr[24:20];
   assign f7  = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};

   // main decoder; anything unrecognised falls through as a NOP
   always_comb begin
      alu_ctrl   = ADD;
      reg_we     = 1'b0;
      mem_we     = 1'b0;
      use_imm    = 1'b0;
      is_beq     = 1'b0;
      mem_to_reg = 1'b0;
      imm        = imm_i;
      unique case (1'b1)
         op == OP_R: begin
            reg_we = 1'b1;
            unique case (1'b1)
               f3 == 3'b000 && f7 == 7'h00: alu_ctrl = ADD;
               f3 == 3'b000 && f7 == 7'h20: alu_ctrl = SUB;
               f3 == 3'b111 && f7 == 7'h00: alu_ctrl = AND;
               f3 == 3'b110 && f7 == 7'h00: alu_ctrl = OR;
               f3 == 3'b010 && f7 == 7'h00: alu_ctrl = SLT;
               default: reg_we = 1'b0;
            endcase
         end
         op == OP_LW: begin
            reg_we     = 1'b1;
            use_imm    = 1'b1;
            mem_to_reg = 1'b1;
         end
         op == OP_SW: begin
            mem_we  = 1'b1;
            use_imm = 1'b1;
            imm     = imm_s;
         end
         op == OP_BEQ: begin
            is_beq   = 1'b1;
            alu_ctrl = SUB;
         end
         default: ;
      endcase
   end

   datapath_regfile #(
      .X10_INIT(DATA_BASE)
   ) u_rf (
      .clk_i (clock),
      .rst_i (clear),
      .ra1_i (rs1),
      .ra2_i (rs2),
      .rd1_o (rd1),
      .rd2_o (rd2),
      .we_i  (reg_we),
      .wa_i  (rd),
      .wd_i  (wb)
   );

   assign alu_a = rd1;
   assign alu_b = use_imm ? imm : rd2;

   // ALU
   always_comb begin
      alu_y = '0;
      unique case (alu_ctrl)
         ADD: alu_y = alu_a + alu_b;
         SUB: alu_y = alu_a - alu_b;
         AND: alu_y = alu_a & alu_b;
         OR:  alu_y = alu_a | alu_b;
         SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default: alu_y = '0;
      endcase
   end

   assign widx     = 30'((alu_y - DATA_BASE) >> 2);
   assign in_range = widx < 30'(DMEM_WORDS);
   assign rdata    = in_range ? dmem_q[widx[AW-1:0]] : '0;
   assign wb       = mem_to_reg ? rdata : alu_y;

   assign dataadr   = alu_y;
   assign writedata = rd2;
   assign memwrite  = mem_we;

   assign pc_d = (is_beq && alu_y == '0) ? pc_q + imm_b : pc_q + 32'd4;

   // program counter
   always_ff @(posedge clock) begin
      if (clear) begin
         pc_q <= TEXT_BASE;
      end else begin
         pc_q <= pc_d;
      end
   end

   // data memory with reset preload; out-of-range stores dropped
   always_ff @(posedge clock) begin
      if (clear) begin
         for (int i = 0; i < DMEM_WORDS; i++) begin
            dmem_q[i] <= '0;
         end
         dmem_q[0] <= 32'd100;
         dmem_q[1] <= 32'd200;
      end else if (mem_we && in_range) begin
         dmem_q[widx[AW-1:0]] <= rd2;
      end
   end

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for the single-cycle datapath: random clear
// pulses, expected state from a program-level reference model.
module tb_datapath;

   localparam logic [31:0] TB_TEXT = 32'h0001_0000;
   localparam logic [31:0] TB_DATA = 32'h1000_0000;
   localparam int NWORDS = 64;
   localparam int NCYC   = 400;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] writedata, dataadr;
   logic        memwrite;

   always #5 clock = ~clock;

   datapath #(
      .TEXT_BASE (TB_TEXT),
      .DATA_BASE (TB_DATA),
      .DMEM_WORDS(NWORDS)
   ) dut (
      .clock    (clock),
      .clear    (clear),
      .writedata(writedata),
      .dataadr  (dataadr),
      .memwrite (memwrite)
   );

   typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_SLT,
                 K_LW, K_SW, K_BEQ, K_NOP} kind_e;

   typedef struct {
      kind_e k;
      int    rd;
      int    rs1;
      int    rs2;
      int    imm;
   } op_t;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] wd;
      logic        mw;
      logic        chk_wd;
      logic [31:0] pc;
      logic [31:0] x3;
      logic [31:0] w2;
   } exp_t;

   op_t         prog [11];
   exp_t        sb [$];
   logic [31:0] m_pc;
   logic [31:0] m_r [32];
   logic [31:0] m_m [NWORDS];
   int          checks = 0;
   int          errors = 0;

   function automatic op_t fetch(input logic [31:0] pc);
      logic [31:0] idx;
      op_t nop;
      nop = '{K_NOP, 0, 0, 0, 0};
      idx = (pc - TB_TEXT) >> 2;
      if (idx < 11) return prog[idx];
      return nop;
   endfunction

   function automatic logic [31:0] rd_reg(input int n);
      return (n == 0) ? 32'd0 : m_r[n];
   endfunction

   function automatic logic [31:0] result(input op_t o);
      logic [31:0] a, b;
      a = rd_reg(o.rs1);
      b = rd_reg(o.rs2);
      case (o.k)
         K_ADD:       return a + b;
         K_SUB:       return a - b;
         K_AND:       return a & b;
         K_OR:        return a | b;
         K_SLT:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         K_LW, K_SW:  return a + 32'(o.imm);
         K_BEQ:       return a - b;
         default:     return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] adr);
      logic [31:0] w;
      w = (adr - TB_DATA) >> 2;
      if (w < NWORDS) return m_m[w];
      return 32'd0;
   endfunction

   task automatic m_reset();
      m_pc = TB_TEXT;
      for (int i = 0; i < 32; i++) m_r[i] = 32'd0;
      m_r[1]  = 32'd1;
      m_r[2]  = 32'd2;
      m_r[10] = TB_DATA;
      for (int i = 0; i < NWORDS; i++) m_m[i] = 32'd0;
      m_m[0] = 32'd100;
      m_m[1] = 32'd200;
   endtask

   task automatic m_step(input logic clr);
      op_t o;
      logic [31:0] y, w;
      if (clr) begin
         m_reset();
         return;
      end
      o = fetch(m_pc);
      y = result(o);
      case (o.k)
         K_ADD, K_SUB, K_AND, K_OR, K_SLT: begin
            if (o.rd != 0) m_r[o.rd] = y;
         end
         K_LW: begin
            if (o.rd != 0) m_r[o.rd] = mem_rd(y);
         end
         K_SW: begin
            w = (y - TB_DATA) >> 2;
            if (w < NWORDS) m_m[w] = rd_reg(o.rs2);
         end
         default: ;
      endcase
      if (o.k == K_BEQ && y == 32'd0) m_pc = m_pc + 32'(o.imm);
      else m_pc = m_pc + 32'd4;
   endtask

   function automatic exp_t predict();
      exp_t e;
      op_t o;
      o = fetch(m_pc);
      e.adr    = result(o);
      e.wd     = rd_reg(o.rs2);
      e.mw     = (o.k == K_SW);
      e.chk_wd = (o.k != K_LW && o.k != K_NOP);
      e.pc     = m_pc;
      e.x3     = m_r[3];
      e.w2     = m_m[2];
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // monitor: compare each cycle's outputs mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc", dut.pc_q, e.pc);
            chk("dataadr", dataadr, e.adr);
            chk("memwrite", {31'd0, memwrite}, {31'd0, e.mw});
            if (e.chk_wd) chk("writedata", writedata, e.wd);
            chk("x3", dut.u_rf.regs_q[3], e.x3);
            chk("dmem2", dut.dmem_q[2], e.w2);
         end
      end
   end

   // driver: random clear pulses plus one fixed mid-program clear
   initial begin
      logic clr;
      prog[0]  = '{K_ADD, 3, 1, 2, 0};
      prog[1]  = '{K_SUB, 3, 1, 2, 0};
      prog[2]  = '{K_AND, 3, 1, 2, 0};
      prog[3]  = '{K_OR,  3, 1, 2, 0};
      prog[4]  = '{K_SLT, 3, 1, 2, 0};
      prog[5]  = '{K_SLT, 3, 2, 1, 0};
      prog[6]  = '{K_BEQ, 0, 10, 0, -24};
      prog[7]  = '{K_LW,  3, 10, 0, 0};
      prog[8]  = '{K_LW,  3, 10, 0, 4};
      prog[9]  = '{K_SW,  0, 10, 3, 8};
      prog[10] = '{K_BEQ, 0, 0, 0, -40};
      clear = 1'b1;
      m_reset();
      @(posedge clock);
      #1;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         if (cyc < 2) clr = 1'b1;
         else if (cyc == 40) clr = 1'b1;
         else clr = ($urandom_range(0, 59) == 0);
         clear = clr;
         sb.push_back(predict());
         @(posedge clock);
         #1;
         m_step(clr);
      end
      repeat (3) @(negedge clock);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clock and clear.
REQ-002 The port list SHALL be, in order:
- clock, input, 1, rising-edge clock.
- clear, input, 1, synchronous active-high reset.
- writedata, output, 32, store data (rs2 value of the current instruction).
- dataadr, output, 32, ALU result (data-memory address for lw/sw).
- memwrite, output, 1, high while the current instruction is sw.
REQ-003 Parameters SHALL be:
- TEXT_BASE, default 32'h0001_0000, reset PC and instruction-ROM base.
- DATA_BASE, default 32'h1000_0000, data-memory base.
- DMEM_WORDS, default 64, data-memory depth in words.

Function
REQ-004 The block SHALL be a single-cycle RV32 datapath: one instruction completes per clock.
REQ-005 It SHALL support add, sub, and, or, slt (R-type), lw, sw (I/S-type) and beq (B-type).
REQ-006 Fetch SHALL read an internal word-addressed ROM at index (PC-TEXT_BASE)>>2.
- ROM holds 11 words at indices 0..10: add/sub/and/or x3,x1,x2; slt x3,x1,x2; slt x3,x2,x1; beq x10,x0,-24; lw x3,0(x10); lw x3,4(x10); sw x3,8(x10); beq x0,x0,-40.
- Any other index SHALL read as NOP (addi x0,x0,0).
REQ-007 The ALU SHALL compute:
- add and lw/sw address: rs1+imm or rs1+rs2, modulo 2^32.
- sub and beq: rs1-rs2.
- and/or: bitwise.
- slt: signed compare, result 1 or 0.
REQ-008 Immediates SHALL be sign-extended (I, S and B formats); the B offset is imm<<1 relative to the branch's own PC.
REQ-009 The next PC SHALL be PC+imm when beq and rs1==rs2, else PC+4.
REQ-010 The register file SHALL have 32x32 registers, two combinational read ports and one write port on the rising edge.
- x0 SHALL always read 0; writes to x0 are ignored.
REQ-011 R-type and lw SHALL write rd on the rising clock edge; sw and beq SHALL not write.
REQ-012 Data memory SHALL be read combinationally at index (dataadr-DATA_BASE)>>2 and written on the rising edge when memwrite=1.
- Out-of-range addresses SHALL read 0 and ignore writes.
- The low 2 address bits are ignored.
REQ-013 writedata, dataadr and memwrite SHALL be combinational functions of the current PC and the current state.
REQ-014 Unsupported opcodes SHALL execute as NOP: no register or memory write, PC+4.

Reset
REQ-015 When clear=1 at a rising edge, the block SHALL load:
- PC=TEXT_BASE.
- All registers 0, except x1=1, x2=2, x10=DATA_BASE.
- Data memory all 0, except word0=100 and word1=200.
REQ-016 While clear=1, no register-file or memory write SHALL occur.
- Outputs SHALL reflect the instruction at TEXT_BASE: dataadr=3, writedata=2, memwrite=0.
REQ-017 Asserting clear mid-program SHALL restore the full reset state on the next edge.

Structure
REQ-018 A shared package datapath_pkg SHALL hold:
- Opcode constants (0110011, 0000011, 0100011, 1100011).
- The ALU-control enum (ADD, SUB, AND, OR, SLT).
- TEXT_BASE and DATA_BASE constants.
REQ-019 The register file SHALL be one sub-module, datapath_regfile, including its reset initialisation; the rest stays in datapath.

Verification
REQ-020 After reset, each cycle -> dataadr:
- add: 3
- sub: 32'hFFFF_FFFF
- and: 0
- or: 3
- slt x1,x2: 1
- slt x2,x1: 0
- x3 SHALL hold that value after each edge.
REQ-021 Cycle 7 beq x10,x0 -> dataadr=32'h1000_0000, branch not taken, next PC=TEXT_BASE+0x1C.
REQ-022 lw cycles:
- lw 0(x10) -> dataadr=32'h1000_0000, x3=100.
- lw 4(x10) -> dataadr=32'h1000_0004, x3=200.
- memwrite=0 in both.
REQ-023 sw cycle -> dataadr=32'h1000_0008, writedata=200, memwrite=1; data word2=200 after the edge.
REQ-024 Cycle 11 beq x0,x0 -> dataadr=0, PC returns to TEXT_BASE, and the sequence repeats (add gives dataadr=3).
REQ-025 clear pulsed mid-program -> PC=TEXT_BASE, x3=0, data word2=0 after the edge.
